// File: rtl/clk_period_meter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : clk_period_meter                                              |
// | Purpose  : Synchronises a slow periodic signal into the clk domain and   |
// |            measures its period and high time in clk cycles, flagging a   |
// |            sticky timeout when rising edges stop arriving.               |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module clk_period_meter #(
  parameter int CNT_W       = 32,
  parameter int TIMEOUT     = 50000000,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  output logic             edge_pulse,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             period_valid,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] c_one      = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_cnt_max  = '1;
  localparam logic [CNT_W-1:0] c_timeout  = CNT_W'(TIMEOUT);

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_MEASURE = 1'b1
  } state_t;

  // Registered state
  logic [SYNC_STAGES-1:0] r_sync_q;
  logic                   r_s_dly_q;
  logic                   r_edge_q;
  logic [CNT_W-1:0]       r_cnt_q;
  logic [CNT_W-1:0]       r_hcnt_q;
  logic [CNT_W-1:0]       r_hold_q;
  logic [CNT_W-1:0]       r_period_q;
  logic [CNT_W-1:0]       r_high_q;
  logic                   r_valid_q;
  logic                   r_timeout_q;
  state_t                 r_state_q;

  // Next-state values
  logic [SYNC_STAGES-1:0] w_sync_d;
  logic                   w_s;
  logic                   w_rise;
  logic                   w_fall;
  logic [CNT_W-1:0]       w_cnt_d;
  logic [CNT_W-1:0]       w_hcnt_d;
  logic [CNT_W-1:0]       w_hold_d;
  logic [CNT_W-1:0]       w_period_d;
  logic [CNT_W-1:0]       w_high_d;
  logic                   w_valid_d;
  logic                   w_timeout_d;
  state_t                 w_state_d;

  // Synchroniser shift and edge detection on the synchronised signal
  always_comb begin
    w_sync_d = {r_sync_q[SYNC_STAGES-2:0], sig_in};
    w_s      = r_sync_q[SYNC_STAGES-1];
    w_rise   = w_s & ~r_s_dly_q;
    w_fall   = ~w_s & r_s_dly_q;
  end

  // Period and high-time counters restart on a rise and saturate instead of wrapping
  always_comb begin
    w_cnt_d  = r_cnt_q;
    w_hcnt_d = r_hcnt_q;
    w_hold_d = r_hold_q;
    if (w_rise) begin
      w_cnt_d  = c_one;
      w_hcnt_d = c_one;
    end else begin
      if (r_cnt_q != c_cnt_max) begin
        w_cnt_d = r_cnt_q + c_one;
      end
      if (w_s && (r_hcnt_q != c_cnt_max)) begin
        w_hcnt_d = r_hcnt_q + c_one;
      end
    end
    // Latch the high run length when the signal drops; reported at the next rise
    if (w_fall) begin
      w_hold_d = r_hcnt_q;
    end
  end

  // Measurement FSM: first rise only arms the count, later rises publish a result
  always_comb begin
    w_state_d   = r_state_q;
    w_period_d  = r_period_q;
    w_high_d    = r_high_q;
    w_valid_d   = 1'b0;
    w_timeout_d = r_timeout_q;
    case (r_state_q)
      ST_IDLE: begin
        if (w_rise) begin
          w_state_d = ST_MEASURE;
        end
      end
      ST_MEASURE: begin
        // A rise coinciding with the timeout count still counts as a valid period
        if (w_rise) begin
          w_period_d  = r_cnt_q;
          w_high_d    = r_hold_q;
          w_valid_d   = 1'b1;
          w_timeout_d = 1'b0;
        end else if (r_cnt_q == c_timeout) begin
          w_timeout_d = 1'b1;
          w_state_d   = ST_IDLE;
        end
      end
      default: begin
        w_state_d = ST_IDLE;
      end
    endcase
  end

  // All state and registered outputs, synchronous active-high reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync_q    <= '0;
      r_s_dly_q   <= 1'b0;
      r_edge_q    <= 1'b0;
      r_cnt_q     <= '0;
      r_hcnt_q    <= '0;
      r_hold_q    <= '0;
      r_period_q  <= '0;
      r_high_q    <= '0;
      r_valid_q   <= 1'b0;
      r_timeout_q <= 1'b0;
      r_state_q   <= ST_IDLE;
    end else begin
      r_sync_q    <= w_sync_d;
      r_s_dly_q   <= w_s;
      r_edge_q    <= w_rise;
      r_cnt_q     <= w_cnt_d;
      r_hcnt_q    <= w_hcnt_d;
      r_hold_q    <= w_hold_d;
      r_period_q  <= w_period_d;
      r_high_q    <= w_high_d;
      r_valid_q   <= w_valid_d;
      r_timeout_q <= w_timeout_d;
      r_state_q   <= w_state_d;
    end
  end

  assign edge_pulse   = r_edge_q;
  assign period       = r_period_q;
  assign high_time    = r_high_q;
  assign period_valid = r_valid_q;
  assign timeout      = r_timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_clk_period_meter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_clk_period_meter                                           |
// | Purpose  : Self-checking bench for clk_period_meter with an event-level  |
// |            reference model and directed square-wave scenarios.          |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_clk_period_meter;

  localparam int CNT_W       = 32;
  localparam int TIMEOUT     = 20;
  localparam int SYNC_STAGES = 2;
  localparam int HL          = SYNC_STAGES + 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             sig_in;
  logic             edge_pulse;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             period_valid;
  logic             timeout;

  clk_period_meter #(
    .CNT_W      (CNT_W),
    .TIMEOUT    (TIMEOUT),
    .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sig_in      (sig_in),
    .edge_pulse  (edge_pulse),
    .period      (period),
    .high_time   (high_time),
    .period_valid(period_valid),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  // Counters: model comparisons and literal comparisons kept separately
  int m_chk = 0, m_pass = 0;
  int l_chk = 0, l_pass = 0;
  int n_valid = 0;

  // Reference model: time-stamp based view of the synchronised signal
  bit      m_hist [HL];
  bit      m_ready = 1'b0;
  int      cyc = 0;
  bit      m_meas, m_edge, m_valid, m_to;
  longint  m_per, m_high, m_hold;
  int      m_last_rise;

  always @(posedge clk) begin
    bit s, sd, rise, fall;
    if (rst) begin
      for (int i = 0; i < HL; i++) m_hist[i] = 1'b0;
      m_meas = 0; m_edge = 0; m_valid = 0; m_to = 0;
      m_per = 0; m_high = 0; m_hold = 0; m_last_rise = 0;
    end else begin
      for (int i = HL - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
      m_hist[0] = sig_in;
      s    = m_hist[SYNC_STAGES];
      sd   = m_hist[SYNC_STAGES+1];
      rise = s && !sd;
      fall = !s && sd;
      m_edge  = rise;
      m_valid = 0;
      if (rise) begin
        if (m_meas) begin
          m_per   = cyc - m_last_rise;
          m_high  = m_hold;
          m_valid = 1;
          m_to    = 0;
        end
        m_meas      = 1;
        m_last_rise = cyc;
      end else if (m_meas && (cyc - m_last_rise) == TIMEOUT) begin
        m_to   = 1;
        m_meas = 0;
      end
      if (fall) m_hold = cyc - m_last_rise;
    end
    cyc++;
    m_ready = 1'b1;
  end

  task automatic mchk(string nm, longint act, longint exp);
    m_chk++;
    if (act == exp) m_pass++;
    else $display("FAIL model %s at cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
  endtask

  task automatic lchk(string nm, longint act, longint exp);
    l_chk++;
    if (act == exp) l_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // Compare every cycle against the model, away from the active edge
  always @(negedge clk) begin
    if (m_ready) begin
      mchk("edge_pulse",   edge_pulse,   m_edge);
      mchk("period_valid", period_valid, m_valid);
      mchk("period",       period,       m_per);
      mchk("high_time",    high_time,    m_high);
      mchk("timeout",      timeout,      m_to);
    end
  end

  // Running count of valid pulses seen on the DUT
  always @(negedge clk) begin
    if (period_valid) n_valid++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wave(int hi, int lo, int n);
    repeat (n) begin
      sig_in = 1'b1;
      repeat (hi) step();
      sig_in = 1'b0;
      repeat (lo) step();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got hang expected finish");
    $fatal(1);
  end

  initial begin
    int base, lat, t_edge, t_to;
    rst    = 1'b1;
    sig_in = 1'b0;

    // Reset held three cycles with sig_in toggling
    repeat (3) begin
      @(posedge clk);
      #1 sig_in = ~sig_in;
    end
    @(negedge clk);
    lchk("reset edge_pulse",   edge_pulse,   0);
    lchk("reset period",       period,       0);
    lchk("reset high_time",    high_time,    0);
    lchk("reset period_valid", period_valid, 0);
    lchk("reset timeout",      timeout,      0);
    @(posedge clk);
    #1;
    rst    = 1'b0;
    sig_in = 1'b0;
    repeat (3) step();

    // Square wave 5/5: four rises give three results; latency of edge_pulse
    base = n_valid;
    lat  = -1;
    fork
      wave(5, 5, 4);
      begin
        for (int i = 1; i <= 10; i++) begin
          @(negedge clk);
          if (edge_pulse && lat < 0) lat = i;
        end
      end
    join
    lchk("edge latency", lat, SYNC_STAGES + 2);
    lchk("5/5 valid count", n_valid - base, 3);
    lchk("5/5 period", period, 10);
    lchk("5/5 high_time", high_time, 5);

    // Duty change 3/7
    base = n_valid;
    wave(3, 7, 4);
    lchk("3/7 valid count", n_valid - base, 4);
    lchk("3/7 period", period, 10);
    lchk("3/7 high_time", high_time, 3);

    // Timeout: one rise, then held low
    t_edge = -1;
    t_to   = -1;
    fork
      begin
        sig_in = 1'b1;
        repeat (3) step();
        sig_in = 1'b0;
        repeat (40) step();
      end
      begin
        for (int i = 0; i < 43; i++) begin
          @(negedge clk);
          if (edge_pulse && t_edge < 0) t_edge = i;
          if (timeout && t_to < 0) t_to = i;
        end
      end
    join
    step();
    lchk("timeout delay", t_to - t_edge, TIMEOUT);
    lchk("timeout flag set", timeout, 1);
    lchk("timeout period kept", period, 10);
    lchk("timeout high kept", high_time, 3);
    base = n_valid;
    wave(5, 5, 2);
    lchk("resume valid count", n_valid - base, 1);
    lchk("resume timeout clear", timeout, 0);
    lchk("resume period", period, 10);
    lchk("resume high_time", high_time, 5);

    // Reset pulse in the middle of a period
    sig_in = 1'b1;
    repeat (5) step();
    sig_in = 1'b0;
    repeat (2) step();
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    lchk("midrst period", period, 0);
    lchk("midrst high_time", high_time, 0);
    lchk("midrst valid", period_valid, 0);
    lchk("midrst timeout", timeout, 0);
    step();
    repeat (2) step();
    base = n_valid;
    wave(5, 5, 2);
    lchk("post-reset valid count", n_valid - base, 1);

    // sig_in toggling every clk
    base = n_valid;
    for (int i = 0; i < 12; i++) begin
      sig_in = ~sig_in;
      step();
    end
    sig_in = 1'b0;
    repeat (5) step();
    lchk("fast valid count", n_valid - base, 6);
    lchk("fast period", period, 2);
    lchk("fast high_time", high_time, 1);

    repeat (3) step();
    $display("%0d/%0d checks passed", m_pass + l_pass, m_chk + l_chk);
    $finish;
  end

endmodule
`default_nettype wire
